iram_arbiter: RTL and testbench

IRAM_ARBITER -- requirements
Module: iram_arbiter

---
 rtl/iram_arbiter.sv | 101 ++++++++++
 tb/tb_iram_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iram_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-ported instruction RAM.
// One access in flight at a time: IDLE samples and latches, ISSUE pulses iram_valid, WAIT forwards.
module iram_arbiter #(
   parameter int ROUND_ROBIN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        imem_valid,
   input  logic        imem_instr,
   input  logic [31:0] imem_addr,
   input  logic [31:0] imem_wdata,
   input  logic [3:0]  imem_wstrb,
   output logic [31:0] imem_rdata,
   output logic        imem_ready,
   input  logic        dmem_valid,
   input  logic        dmem_instr,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   input  logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_rdata,
   output logic        dmem_ready,
   output logic        iram_valid,
   output logic        iram_instr,
   output logic [31:0] iram_addr,
   output logic [31:0] iram_wdata,
   output logic [3:0]  iram_wstrb,
   input  logic [31:0] iram_rdata,
   input  logic        iram_ready
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   // Last grant, 1 = dmem; it also selects the port owning the access in flight.
   logic        r_last_dmem;
   logic        r_instr;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic        w_take;
   logic        w_pick_dmem;
   logic        w_done;

   always_comb begin
      w_pick_dmem = dmem_valid;
      if (imem_valid && dmem_valid)
         w_pick_dmem = (ROUND_ROBIN != 0) ? ~r_last_dmem : 1'b0;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (imem_valid || dmem_valid) begin
               w_take      = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT:  if (iram_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_last_dmem <= 1'b1;
         r_instr     <= 1'b0;
         r_addr      <= 32'h0;
         r_wdata     <= 32'h0;
         r_wstrb     <= 4'h0;
      end else begin
         r_state <= w_state_nxt;
         if (w_take) begin
            r_last_dmem <= w_pick_dmem;
            r_instr     <= w_pick_dmem ? dmem_instr : imem_instr;
            r_addr      <= w_pick_dmem ? dmem_addr  : imem_addr;
            r_wdata     <= w_pick_dmem ? dmem_wdata : imem_wdata;
            r_wstrb     <= w_pick_dmem ? dmem_wstrb : imem_wstrb;
         end
      end
   end

   // Completion is only honoured in WAIT; a reset in that cycle swallows it.
   assign w_done     = (r_state == S_WAIT) && iram_ready && !rst;

   assign iram_valid = (r_state == S_ISSUE);
   assign iram_instr = r_instr;
   assign iram_addr  = r_addr;
   assign iram_wdata = r_wdata;
   assign iram_wstrb = r_wstrb;

   assign imem_ready = w_done && !r_last_dmem;
   assign dmem_ready = w_done &&  r_last_dmem;
   assign imem_rdata = imem_ready ? iram_rdata : 32'h0;
   assign dmem_rdata = dmem_ready ? iram_rdata : 32'h0;

endmodule

// File: tb/tb_iram_arbiter.sv
// Bench for iram_arbiter: table of single accesses against a RAM model with a response
// scoreboard, plus sequences for contention, reset during WAIT, slow RAM and fixed priority.
module tb_iram_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        imem_valid, imem_instr, dmem_valid, dmem_instr;
   logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
   logic [3:0]  imem_wstrb, dmem_wstrb;
   logic [31:0] imem_rdata, dmem_rdata;
   logic        imem_ready, dmem_ready;
   logic        iram_valid, iram_instr;
   logic [31:0] iram_addr, iram_wdata, iram_rdata;
   logic [3:0]  iram_wstrb;
   logic        iram_ready;

   logic        fp_iv, fp_dv, fp_instr;
   logic [31:0] fp_ia, fp_da, fp_wd;
   logic [3:0]  fp_ws;
   logic [31:0] fp_irdata, fp_drdata;
   logic        fp_irdy, fp_drdy;
   logic        fp_iram_valid, fp_iram_instr;
   logic [31:0] fp_iram_addr, fp_iram_wdata;
   logic [3:0]  fp_iram_wstrb;
   logic [31:0] fp_iram_rdata;
   logic        fp_iram_ready = 1'b0;

   iram_arbiter #(.ROUND_ROBIN(1)) u_dut (
      .clk(clk), .rst(rst),
      .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .iram_valid(iram_valid), .iram_instr(iram_instr), .iram_addr(iram_addr),
      .iram_wdata(iram_wdata), .iram_wstrb(iram_wstrb), .iram_rdata(iram_rdata), .iram_ready(iram_ready)
   );

   iram_arbiter #(.ROUND_ROBIN(0)) u_fp (
      .clk(clk), .rst(rst),
      .imem_valid(fp_iv), .imem_instr(fp_instr), .imem_addr(fp_ia),
      .imem_wdata(fp_wd), .imem_wstrb(fp_ws), .imem_rdata(fp_irdata), .imem_ready(fp_irdy),
      .dmem_valid(fp_dv), .dmem_instr(fp_instr), .dmem_addr(fp_da),
      .dmem_wdata(fp_wd), .dmem_wstrb(fp_ws), .dmem_rdata(fp_drdata), .dmem_ready(fp_drdy),
      .iram_valid(fp_iram_valid), .iram_instr(fp_iram_instr), .iram_addr(fp_iram_addr),
      .iram_wdata(fp_iram_wdata), .iram_wstrb(fp_iram_wstrb), .iram_rdata(fp_iram_rdata),
      .iram_ready(fp_iram_ready)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] ws);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // RAM model: samples iram_valid, answers ram_delay cycles later; rdata is junk when not ready.
   logic [31:0] mem [0:255];
   int          ram_delay = 1;
   int          ram_cnt = 0;
   logic [31:0] ram_word;
   logic        ram_rdy = 1'b0;
   logic        stray_rdy = 1'b0;
   assign iram_ready = ram_rdy | stray_rdy;

   always @(posedge clk) begin
      ram_rdy    <= 1'b0;
      iram_rdata <= 32'hBAD0_BAD0;
      if (ram_cnt > 1) ram_cnt <= ram_cnt - 1;
      else if (ram_cnt == 1) begin
         ram_cnt    <= 0;
         ram_rdy    <= 1'b1;
         iram_rdata <= ram_word;
      end else if (iram_valid) begin
         ram_word              <= mem[iram_addr[9:2]];
         mem[iram_addr[9:2]]   <= merge(mem[iram_addr[9:2]], iram_wdata, iram_wstrb);
         if (ram_delay <= 1) begin
            ram_rdy    <= 1'b1;
            iram_rdata <= mem[iram_addr[9:2]];
         end else ram_cnt <= ram_delay - 1;
      end
   end

   always @(posedge clk) begin
      fp_iram_ready <= fp_iram_valid;
      fp_iram_rdata <= fp_iram_valid ? fp_iram_addr : 32'hBAD0_BAD0;
   end

   typedef struct { bit port; logic [31:0] rdata; } exp_t;
   exp_t sb[$];
   int   pulse_cyc[$];
   int   pulse_cnt = 0;
   int   cyc = 0;
   int   fp_i_cnt = 0;
   int   fp_d_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      if (cyc >= 1) begin
         chk("imem_rdata_gated", imem_ready ? 32'h0 : imem_rdata, 32'h0);
         chk("dmem_rdata_gated", dmem_ready ? 32'h0 : dmem_rdata, 32'h0);
         chk("single_ready", imem_ready & dmem_ready, 0);
         if (imem_ready || dmem_ready) begin
            pulse_cnt++;
            pulse_cyc.push_back(cyc);
            chk("sb_expects_ready", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("grant_port", dmem_ready, e.port);
               chk("resp_rdata", dmem_ready ? dmem_rdata : imem_rdata, e.rdata);
            end
         end
         if (fp_irdy) begin
            fp_i_cnt++;
            chk("fp_imem_rdata", fp_irdata, fp_ia);
         end
         if (fp_drdy) begin
            fp_d_cnt++;
            chk("fp_dmem_rdata", fp_drdata, fp_da);
         end
      end
   end

   typedef struct {
      bit          iv, dv;
      logic [31:0] ia, da, dwd;
      logic [3:0]  dws;
      bit          ep;
      logic [31:0] er;
   } vec_t;

   localparam logic [31:0] IWD = 32'h1234_5678;

   function automatic vec_t mkv(input bit iv, input bit dv, input logic [31:0] ia,
                                input logic [31:0] da, input logic [31:0] dwd,
                                input logic [3:0] dws, input bit ep, input logic [31:0] er);
      vec_t v;
      v.iv = iv; v.dv = dv; v.ia = ia; v.da = da; v.dwd = dwd;
      v.dws = dws; v.ep = ep; v.er = er;
      return v;
   endfunction

   // Called just after a rising edge in IDLE; returns just after the edge that re-enters IDLE.
   task automatic apply(input vec_t v);
      imem_valid = v.iv; imem_instr = 1'b1; imem_addr = v.ia; imem_wdata = IWD; imem_wstrb = 4'h0;
      dmem_valid = v.dv; dmem_instr = 1'b0; dmem_addr = v.da; dmem_wdata = v.dwd; dmem_wstrb = v.dws;
      sb.push_back('{port: v.ep, rdata: v.er});
      @(negedge clk);
      chk("idle_no_issue", iram_valid, 0);
      @(negedge clk);
      chk("issue_valid", iram_valid, 1);
      chk("issue_addr", iram_addr, v.ep ? v.da : v.ia);
      chk("issue_wdata", iram_wdata, v.ep ? v.dwd : IWD);
      chk("issue_wstrb", iram_wstrb, v.ep ? v.dws : 4'h0);
      chk("issue_instr", iram_instr, !v.ep);
      @(negedge clk);
      chk("ready_at_n2", v.ep ? dmem_ready : imem_ready, 1);
      chk("other_idle", v.ep ? imem_ready : dmem_ready, 0);
      chk("valid_one_cycle", iram_valid, 0);
      @(posedge clk); #1;
      imem_valid = 1'b0; dmem_valid = 1'b0;
   endtask

   initial begin
      vec_t vt [9];
      int   base;
      for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + i;
      mem[4]  = 32'h0000_0013;
      mem[65] = 32'h1122_3344;

      vt[0] = mkv(1, 0, 32'h10, 32'h0,   32'h0,         4'h0, 0, 32'h0000_0013);
      vt[1] = mkv(0, 1, 32'h0,  32'h104, 32'hAABBCCDD,  4'h2, 1, 32'h1122_3344);
      vt[2] = mkv(0, 1, 32'h0,  32'h104, 32'h0,         4'h0, 1, 32'h1122_CC44);
      vt[3] = mkv(1, 1, 32'h20, 32'h30,  32'h0,         4'h0, 0, 32'hC0DE_0008);
      vt[4] = mkv(1, 1, 32'h24, 32'h34,  32'h0,         4'h0, 1, 32'hC0DE_000D);
      vt[5] = mkv(1, 0, 32'h40, 32'h0,   32'h0,         4'h0, 0, 32'hC0DE_0010);
      vt[6] = mkv(1, 1, 32'h44, 32'h48,  32'h0,         4'h0, 1, 32'hC0DE_0012);
      vt[7] = mkv(0, 1, 32'h0,  32'h50,  32'hDEADBEEF,  4'hF, 1, 32'hC0DE_0014);
      vt[8] = mkv(1, 0, 32'h50, 32'h0,   32'h0,         4'h0, 0, 32'hDEAD_BEEF);

      rst = 1'b1;
      imem_valid = 0; imem_instr = 0; imem_addr = 0; imem_wdata = 0; imem_wstrb = 0;
      dmem_valid = 0; dmem_instr = 0; dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0;
      fp_iv = 0; fp_dv = 0; fp_instr = 0; fp_ia = 32'h100; fp_da = 32'h200; fp_wd = 0; fp_ws = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_iram_valid", iram_valid, 0);
      chk("rst_iram_instr", iram_instr, 0);
      chk("rst_iram_addr", iram_addr, 0);
      chk("rst_iram_wdata", iram_wdata, 0);
      chk("rst_iram_wstrb", iram_wstrb, 0);
      chk("rst_readies", {imem_ready, dmem_ready}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 9; i++) apply(vt[i]);

      // Round-robin contention straight out of reset: imem, dmem, imem, dmem.
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      pulse_cyc.delete();
      base = pulse_cnt;
      imem_valid = 1; imem_instr = 1; imem_addr = 32'h70; imem_wdata = IWD; imem_wstrb = 0;
      dmem_valid = 1; dmem_instr = 0; dmem_addr = 32'h74; dmem_wdata = 0;   dmem_wstrb = 0;
      for (int k = 0; k < 2; k++) begin
         sb.push_back('{port: 1'b0, rdata: 32'hC0DE_001C});
         sb.push_back('{port: 1'b1, rdata: 32'hC0DE_001D});
      end
      for (int t = 0; t < 20 && pulse_cnt < base + 4; t++) begin
         @(negedge clk); #1;
      end
      chk("rr_pulse_count", pulse_cnt - base, 4);
      if (pulse_cyc.size() >= 4)
         for (int k = 1; k < 4; k++) chk("rr_spacing", pulse_cyc[k] - pulse_cyc[k-1], 3);
      @(posedge clk); #1;
      imem_valid = 0; dmem_valid = 0;
      @(posedge clk); #1;

      // Reset lands in the WAIT cycle where the RAM answers.
      imem_valid = 1; imem_addr = 32'h10;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rstwait_ram_ready", iram_ready, 1);
      chk("rstwait_no_ready", {imem_ready, dmem_ready}, 0);
      @(posedge clk); #1;
      rst = 1'b0; imem_valid = 0;
      @(negedge clk);
      chk("rstwait_idle_valid", iram_valid, 0);
      chk("rstwait_addr_clr", iram_addr, 0);
      @(posedge clk); #1;
      stray_rdy = 1'b1;
      @(negedge clk);
      chk("stray_ignored", {imem_ready, dmem_ready}, 0);
      @(posedge clk); #1;
      stray_rdy = 1'b0;
      apply(vt[0]);

      // Slow RAM: ready three cycles after the issue; request changes must not leak in.
      ram_delay = 3;
      base = pulse_cnt;
      dmem_valid = 1; dmem_addr = 32'h104; dmem_wdata = 0; dmem_wstrb = 0;
      sb.push_back('{port: 1'b1, rdata: 32'h1122_CC44});
      @(negedge clk);
      @(negedge clk);
      chk("slow_issue", iram_valid, 1);
      @(posedge clk); #1;
      dmem_addr = 32'h0; dmem_wstrb = 4'hF;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("slow_hold_valid", iram_valid, 0);
         chk("slow_hold_addr", iram_addr, 32'h104);
         chk("slow_hold_wstrb", iram_wstrb, 0);
         chk("slow_no_ready", dmem_ready, 0);
      end
      @(negedge clk);
      chk("slow_ready", dmem_ready, 1);
      chk("slow_addr_final", iram_addr, 32'h104);
      @(posedge clk); #1;
      dmem_valid = 0; dmem_wstrb = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("slow_one_pulse", pulse_cnt - base, 1);
      ram_delay = 1;

      // Fixed priority: imem holds the RAM, dmem waits until imem lets go.
      @(posedge clk); #1;
      base = fp_i_cnt;
      fp_iv = 1; fp_dv = 1;
      repeat (9) @(negedge clk);
      #1;
      chk("fp_imem_served", fp_i_cnt - base, 3);
      chk("fp_dmem_starved", fp_d_cnt, 0);
      @(posedge clk); #1;
      fp_iv = 0;
      for (int t = 0; t < 8 && fp_d_cnt == 0; t++) begin
         @(negedge clk); #1;
      end
      chk("fp_dmem_after", fp_d_cnt, 1);
      fp_dv = 0;

      repeat (4) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
